// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: diff = a - b - bin (mod 2^WIDTH), LSB first, one bit per clock.
// Start is accepted only when idle; done pulses for one cycle when diff and bout are updated.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] dw_q, dw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;

  logic a_bit, b_bit, d_bit, br_next;

  // Single full-subtractor cell operating on the current LSBs and the borrow flop.
  always_comb begin
    a_bit   = a_q[0];
    b_bit   = b_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dw_d    = dw_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          dw_d    = '0;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        dw_d  = (dw_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
        cnt_d = cnt_q + 1'b1;
        // Last bit: publish the completed word on the same edge that leaves SHIFT.
        if (cnt_q == LAST) begin
          state_d = IDLE;
          diff_d  = dw_d;
          bout_d  = br_next;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dw_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dw_q    <= dw_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1 against an arithmetic reference.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    int         cyc;
  } exp_t;

  logic       clk, rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start1, bin1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;

  exp_t q8[$];
  exp_t q1[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   dones8 = 0;
  int   bcnt8 = 0, bcnt1 = 0;
  logic [7:0] hold8_d = '0;
  logic       hold8_b = 1'b0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(int w, int a, int b, int bi, int c);
    exp_t e;
    int   r;
    r = a - b - bi;
    if (r < 0) r += (1 << w);
    e.d   = 8'(r);
    e.bo  = (a < b + bi);
    e.cyc = c;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 100) begin tick(); n++; end
    chk("u8 idle timeout", 32'(busy8), 32'd0);
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 100) begin tick(); n++; end
    chk("u8 done timeout", 32'(done8), 32'd1);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    wait_idle8();
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    q8.push_back(model(8, int'(a), int'(b), int'(bi), cyc + 1 + 8));
    tick();
    start8 = 1'b0;
  endtask

  task automatic issue1(input logic a, input logic b, input logic bi);
    int n = 0;
    while (busy1 && n < 100) begin tick(); n++; end
    chk("u1 idle timeout", 32'(busy1), 32'd0);
    a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
    q1.push_back(model(1, int'(a), int'(b), int'(bi), cyc + 1 + 1));
    tick();
    start1 = 1'b0;
  endtask

  // Monitor for the 8-bit instance: result, latency, busy length and hold behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q8.delete();
      hold8_d = '0;
      hold8_b = 1'b0;
      bcnt8   = 0;
    end else begin
      if (busy8) bcnt8++;
      if (done8) begin
        dones8++;
        if (q8.size() == 0) chk("u8 spurious done", 32'd1, 32'd0);
        else begin
          e = q8.pop_front();
          chk("u8 diff", 32'(diff8), 32'(e.d));
          chk("u8 bout", 32'(bout8), 32'(e.bo));
          chk("u8 done cycle", cyc, e.cyc);
          chk("u8 busy length", bcnt8, 8);
          hold8_d = e.d;
          hold8_b = e.bo;
        end
        bcnt8 = 0;
      end else if (busy8) begin
        chk("u8 diff hold", 32'({bout8, diff8}), 32'({hold8_b, hold8_d}));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q1.delete();
      bcnt1 = 0;
    end else begin
      if (busy1) bcnt1++;
      if (done1) begin
        if (q1.size() == 0) chk("u1 spurious done", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("u1 diff/bout", 32'({bout1, diff1}), 32'({e.bo, e.d[0]}));
          chk("u1 done cycle", cyc, e.cyc);
          chk("u1 busy length", bcnt1, 1);
        end
        bcnt1 = 0;
      end
    end
  end

  initial begin
    int d0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset u8 busy/done", 32'({busy8, done8}), 32'd0);
    chk("reset u8 diff", 32'(diff8), 32'd0);
    chk("reset u8 bout", 32'(bout8), 32'd0);
    chk("reset u1 outputs", 32'({busy1, done1, diff1, bout1}), 32'd0);
    tick();

    issue8(8'h05, 8'h03, 1'b0); wait_done8();
    issue8(8'h03, 8'h05, 1'b0); wait_done8();
    issue8(8'h00, 8'h00, 1'b1); wait_done8();
    issue8(8'hFF, 8'hFF, 1'b0); wait_done8();

    // Start while busy must be ignored.
    issue8(8'h10, 8'h01, 1'b0);
    repeat (2) tick();
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8();

    // Back-to-back: start accepted in the done cycle.
    issue8(8'h80, 8'h01, 1'b0);
    wait_done8();

    for (int k = 0; k < 8; k++) begin
      logic [2:0] kv;
      kv = 3'(k);
      issue1(kv[2], kv[1], kv[0]);
    end
    repeat (3) tick();

    // Reset mid-operation aborts silently.
    issue8(8'h20, 8'h10, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy/done", 32'({busy8, done8}), 32'd0);
    chk("abort diff/bout", 32'({bout8, diff8}), 32'd0);
    d0 = dones8;
    repeat (12) tick();
    chk("no done after abort", dones8 - d0, 0);
    issue8(8'h20, 8'h10, 1'b0);
    wait_done8();

    repeat (40) begin
      repeat ($urandom_range(0, 2)) tick();
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
      // Noise during the operation: ignored starts and changing operands.
      while (busy8) begin
        start8 = 1'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        tick();
      end
      start8 = 1'b0;
    end

    repeat (20) begin
      repeat ($urandom_range(0, 2)) tick();
      issue1(1'($urandom), 1'($urandom), 1'($urandom));
    end

    wait_idle8();
    repeat (4) tick();
    chk("u8 queue drained", q8.size(), 0);
    chk("u1 queue drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
